// File: rtl/queue_node_writer_pkg.sv
// rtl/queue_node_writer_pkg.sv - shared pathfinding node types, slot ids and writer enums
package queue_node_writer_pkg;

  localparam logic [15:0] NODE_EMPTY_ID   = 16'd0;
  localparam logic [15:0] NODE_REMOVED_ID = 16'd800;

  typedef struct packed {
    logic [15:0] x;
    logic [15:0] y;
    logic [7:0]  terrain;
    logic [7:0]  flags;
  } map_node_t;

  typedef struct packed {
    logic [15:0]      node_id;
    logic [15:0]      parent_node_id;
    logic [15:0]      current_cost;
    logic [15:0]      heuristic_cost;
    logic [15:0]      total_cost;
    map_node_t        location;
    logic [7:0][15:0] neighbor_ids;
    logic [15:0]      depth;
  } node_info_t;

  // Removed slot: scans skip it and INSERT may reuse it.
  localparam node_info_t TOMBSTONE_NODE =
    node_info_t'({NODE_REMOVED_ID, NODE_REMOVED_ID, 16'hFFFF, 224'h0});

  typedef enum logic [1:0] {OP_CLEAR, OP_INSERT, OP_UPDATE, OP_REMOVE} op_e;
  typedef enum logic [1:0] {ERR_NONE, ERR_ADDR, ERR_RESERVED, ERR_SLOT} err_code_e;
  typedef enum logic [2:0] {IDLE, CLEAR_SWEEP, RD_WAIT, CHECK, WRITE, DONE} state_e;

  function automatic logic is_reserved_id(input logic [15:0] id);
    return (id == NODE_EMPTY_ID) || (id == NODE_REMOVED_ID);
  endfunction

endpackage

// File: rtl/queue_node_writer_if.sv
// rtl/queue_node_writer_if.sv - command handshake plus node RAM read/write port
interface queue_node_writer_if
  import queue_node_writer_pkg::*;
#(
  parameter int ADDR_W = 7
);
  logic              cmd_valid;
  logic              cmd_ready;
  logic [1:0]        cmd_op;
  logic [ADDR_W-1:0] cmd_addr;
  node_info_t        cmd_node;
  logic [ADDR_W-1:0] read_address;
  node_info_t        read_node;
  logic              write_enable;
  logic [ADDR_W-1:0] write_address;
  node_info_t        write_data;

  modport master (
    output cmd_valid, cmd_op, cmd_addr, cmd_node, read_node,
    input  cmd_ready, read_address, write_enable, write_address, write_data
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_addr, cmd_node, read_node,
    output cmd_ready, read_address, write_enable, write_address, write_data
  );
endinterface

// File: rtl/queue_entry_merge.sv
// rtl/queue_entry_merge.sv - slot check and write-data merge for INSERT/UPDATE/REMOVE
module queue_entry_merge
  import queue_node_writer_pkg::*;
(
  input  op_e        op,
  input  node_info_t stored,
  input  node_info_t cmd_node,
  output node_info_t write_data,
  output err_code_e  err_code
);
  always_comb begin
    write_data = stored;
    err_code   = ERR_NONE;
    case (op)
      OP_INSERT: begin
        write_data = cmd_node;
        if (!is_reserved_id(stored.node_id)) err_code = ERR_SLOT;
      end
      OP_UPDATE: begin
        write_data.parent_node_id = cmd_node.parent_node_id;
        write_data.current_cost   = cmd_node.current_cost;
        if (stored.node_id != cmd_node.node_id) err_code = ERR_SLOT;
      end
      OP_REMOVE: begin
        write_data = TOMBSTONE_NODE;
        if (stored.node_id != cmd_node.node_id) err_code = ERR_SLOT;
      end
      default: ;
    endcase
  end
endmodule

// File: rtl/queue_node_writer.sv
// rtl/queue_node_writer.sv - node queue RAM write controller; QUEUE_WRITER_SLOT_CHECK_EN enables INSERT/REMOVE slot reads
module queue_node_writer
  import queue_node_writer_pkg::*;
#(
  parameter int MAX_NODES = 100,
  parameter int ADDR_W    = 7,
  localparam int CNT_W    = $clog2(MAX_NODES + 1)
) (
  input  logic               clk,
  input  logic               reset,
  queue_node_writer_if.slave bus,
  output logic               busy,
  output logic               done,
  output logic               error,
  output logic [1:0]         err_code,
  output logic [CNT_W-1:0]   live_count
);
  state_e            state;
  op_e               op_q;
  logic [ADDR_W-1:0] addr_q;
  node_info_t        node_q;
  logic              write_enable;
  logic [ADDR_W-1:0] write_address;
  logic [ADDR_W-1:0] read_address;
  node_info_t        write_data;
  err_code_e         err_q;
  op_e               cmd_op;
  err_code_e         accept_err;
  err_code_e         merge_err;
  node_info_t        merge_data;

  assign cmd_op            = op_e'(bus.cmd_op);
  assign bus.cmd_ready     = (state == IDLE) && !reset;
  assign bus.read_address  = read_address;
  assign bus.write_enable  = write_enable;
  assign bus.write_address = write_address;
  assign bus.write_data    = write_data;
  assign busy              = (state != IDLE);
  assign err_code          = err_q;

  always_comb begin
    accept_err = ERR_NONE;
    if (cmd_op != OP_CLEAR) begin
      if (int'(bus.cmd_addr) >= MAX_NODES) accept_err = ERR_ADDR;
      else if (is_reserved_id(bus.cmd_node.node_id)) accept_err = ERR_RESERVED;
    end
  end

  queue_entry_merge u_merge (
    .op         (op_q),
    .stored     (bus.read_node),
    .cmd_node   (node_q),
    .write_data (merge_data),
    .err_code   (merge_err)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      op_q          <= OP_CLEAR;
      addr_q        <= '0;
      node_q        <= '0;
      write_enable  <= 1'b0;
      write_address <= '0;
      write_data    <= '0;
      read_address  <= '0;
      done          <= 1'b0;
      error         <= 1'b0;
      err_q         <= ERR_NONE;
      live_count    <= '0;
    end else begin
      write_enable <= 1'b0;
      done         <= 1'b0;
      error        <= 1'b0;
      case (state)
        IDLE: if (bus.cmd_valid) begin
          op_q   <= cmd_op;
          addr_q <= bus.cmd_addr;
          node_q <= bus.cmd_node;
          err_q  <= accept_err;
          if (accept_err != ERR_NONE) begin
            state <= DONE;
            done  <= 1'b1;
            error <= 1'b1;
          end else begin
            case (cmd_op)
              OP_CLEAR: begin
                state         <= CLEAR_SWEEP;
                write_enable  <= 1'b1;
                write_address <= '0;
                write_data    <= '0;
              end
              OP_UPDATE: begin
                state        <= RD_WAIT;
                read_address <= bus.cmd_addr;
              end
              default: begin
`ifdef QUEUE_WRITER_SLOT_CHECK_EN
                state        <= RD_WAIT;
                read_address <= bus.cmd_addr;
`else
                state         <= WRITE;
                write_enable  <= 1'b1;
                write_address <= bus.cmd_addr;
                write_data    <= (cmd_op == OP_INSERT) ? bus.cmd_node : TOMBSTONE_NODE;
`endif
              end
            endcase
          end
        end
        CLEAR_SWEEP: begin
          if (write_address == ADDR_W'(MAX_NODES - 1)) begin
            state      <= DONE;
            done       <= 1'b1;
            live_count <= '0;
          end else begin
            write_enable  <= 1'b1;
            write_address <= write_address + 1'b1;
          end
        end
        RD_WAIT: state <= CHECK;
        CHECK: begin
          if (merge_err != ERR_NONE) begin
            state <= DONE;
            done  <= 1'b1;
            error <= 1'b1;
            err_q <= merge_err;
          end else begin
            state         <= WRITE;
            write_enable  <= 1'b1;
            write_address <= addr_q;
            write_data    <= merge_data;
          end
        end
        WRITE: begin
          state <= DONE;
          done  <= 1'b1;
          if (op_q == OP_INSERT && live_count != CNT_W'(MAX_NODES))
            live_count <= live_count + 1'b1;
          else if (op_q == OP_REMOVE && live_count != '0)
            live_count <= live_count - 1'b1;
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_queue_node_writer.sv
// tb/tb_queue_node_writer.sv - randomized self-checking bench for queue_node_writer
module tb_queue_node_writer;
  import queue_node_writer_pkg::*;

  localparam int MAXN = 100;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       busy, done, error;
  logic [1:0] err_code;
  logic [6:0] live_count;

  always #5 clk = ~clk;

  queue_node_writer_if #(.ADDR_W(7)) bus ();

  queue_node_writer #(.MAX_NODES(MAXN), .ADDR_W(7)) dut (
    .clk        (clk),
    .reset      (reset),
    .bus        (bus),
    .busy       (busy),
    .done       (done),
    .error      (error),
    .err_code   (err_code),
    .live_count (live_count)
  );

  node_info_t ram [128];
  logic [6:0] wq_addr [$];
  node_info_t wq_data [$];

  always @(posedge clk) begin
    if (bus.write_enable === 1'b1) ram[bus.write_address] <= bus.write_data;
    bus.read_node <= ram[bus.read_address];
  end

  always @(posedge clk) begin
    if (bus.write_enable === 1'b1) begin
      wq_addr.push_back(bus.write_address);
      wq_data.push_back(bus.write_data);
    end
  end

  node_info_t mram [MAXN];
  int         mlive = 0;
  int         total = 0;
  int         bad = 0;

  task automatic check(input string tag, input logic [271:0] obs, input logic [271:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic node_info_t rand_node();
    logic [287:0] v;
    for (int i = 0; i < 9; i++) v[i*32 +: 32] = $urandom;
    return node_info_t'(v[271:0]);
  endfunction

  task automatic run_cmd(input op_e op, input int addr, input node_info_t node);
    int         e, lat, nw, k, n, diffs;
    bit         slot_free, match;
    node_info_t exp_d;
    e = 0; lat = 0; exp_d = '0; slot_free = 1'b0; match = 1'b0;
    if (op != OP_CLEAR) begin
      if (addr >= MAXN) e = 1;
      else if (node.node_id == 16'd0 || node.node_id == 16'd800) e = 2;
    end
    if (e == 0 && op != OP_CLEAR) begin
      slot_free = (mram[addr].node_id == 16'd0) || (mram[addr].node_id == 16'd800);
      match     = (mram[addr].node_id == node.node_id);
    end
    if (e == 0) begin
      case (op)
        OP_CLEAR: lat = MAXN;
        OP_UPDATE: begin if (!match) e = 3; lat = (e == 0) ? 3 : 2; end
`ifdef QUEUE_WRITER_SLOT_CHECK_EN
        OP_INSERT: begin if (!slot_free) e = 3; lat = (e == 0) ? 3 : 2; end
        OP_REMOVE: begin if (!match) e = 3; lat = (e == 0) ? 3 : 2; end
`else
        default: lat = 1;
`endif
      endcase
    end
    if (e == 0) begin
      case (op)
        OP_INSERT: exp_d = node;
        OP_UPDATE: begin
          exp_d = mram[addr];
          exp_d.parent_node_id = node.parent_node_id;
          exp_d.current_cost   = node.current_cost;
        end
        OP_REMOVE: begin
          exp_d.node_id        = 16'd800;
          exp_d.parent_node_id = 16'd800;
          exp_d.current_cost   = 16'hFFFF;
        end
        default: ;
      endcase
    end
    nw = (e != 0) ? 0 : (op == OP_CLEAR) ? MAXN : 1;

    n = 0;
    while (bus.cmd_ready !== 1'b1 && n < 20) begin @(posedge clk); #1; n++; end
    check("ready_wait", bus.cmd_ready, 1'b1);
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = op;
    bus.cmd_addr  = 7'(addr);
    bus.cmd_node  = node;
    wq_addr.delete();
    wq_data.delete();
    @(posedge clk); #1;
    bus.cmd_valid = 1'b0;
    check("ready_low", bus.cmd_ready, 1'b0);
    check("busy_high", busy, 1'b1);
    k = 0;
    while (done !== 1'b1 && k < MAXN + 10) begin @(posedge clk); #1; k++; end
    check("latency", k, lat);
    check("error", error, e != 0);
    check("err_code", err_code, e);

    if (e == 0) begin
      case (op)
        OP_CLEAR:  begin for (int i = 0; i < MAXN; i++) mram[i] = '0; mlive = 0; end
        OP_INSERT: begin mram[addr] = exp_d; if (mlive < MAXN) mlive++; end
        OP_UPDATE: mram[addr] = exp_d;
        OP_REMOVE: begin mram[addr] = exp_d; if (mlive > 0) mlive--; end
      endcase
    end
    check("live_count", live_count, mlive);
    check("write_count", wq_addr.size(), nw);
    if (op == OP_CLEAR && wq_addr.size() == MAXN) begin
      diffs = 0;
      for (int i = 0; i < MAXN; i++)
        if (wq_addr[i] !== 7'(i) || wq_data[i] !== '0) diffs++;
      check("clear_sweep_diffs", diffs, 0);
    end else if (nw == 1 && wq_addr.size() == 1) begin
      check("write_addr", wq_addr[0], addr);
      check("write_data", wq_data[0], exp_d);
    end
    @(posedge clk); #1;
    check("done_pulse", done, 1'b0);
    check("ready_back", bus.cmd_ready, 1'b1);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  initial begin
    node_info_t nd, nu;
    int         n, a, r, pick;
    op_e        op;

    bus.cmd_valid = 1'b0;
    bus.cmd_op    = 2'd0;
    bus.cmd_addr  = '0;
    bus.cmd_node  = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_write_enable", bus.write_enable, 1'b0);
    check("rst_write_address", bus.write_address, 7'd0);
    check("rst_write_data", bus.write_data, '0);
    check("rst_read_address", bus.read_address, 7'd0);
    check("rst_done", done, 1'b0);
    check("rst_error", error, 1'b0);
    check("rst_err_code", err_code, 2'd0);
    check("rst_live_count", live_count, 7'd0);
    check("rst_busy", busy, 1'b0);
    check("rst_cmd_ready", bus.cmd_ready, 1'b0);
    reset = 1'b0;
    #1;
    check("ready_after_reset", bus.cmd_ready, 1'b1);

    nd = rand_node();
    nd.node_id = 16'd5; nd.current_cost = 16'd40; nd.location.x = 16'd17;
    run_cmd(OP_CLEAR, 0, nd);
    run_cmd(OP_INSERT, 0, nd);
    run_cmd(OP_INSERT, 0, nd);
    nu = rand_node();
    nu.node_id = 16'd5; nu.current_cost = 16'd12; nu.parent_node_id = 16'd3; nu.location.x = 16'd99;
    run_cmd(OP_UPDATE, 0, nu);
    check("upd_ram_x", ram[0].location.x, 16'd17);
    check("upd_ram_cost", ram[0].current_cost, 16'd12);
    check("upd_ram_parent", ram[0].parent_node_id, 16'd3);
    run_cmd(OP_REMOVE, 0, nd);
    check("rm_ram_tomb", ram[0], {16'd800, 16'd800, 16'hFFFF, 224'h0});
    nd = rand_node(); nd.node_id = 16'd7;
    run_cmd(OP_INSERT, 0, nd);
    run_cmd(OP_INSERT, 100, nd);
    nd.node_id = 16'd800;
    run_cmd(OP_INSERT, 1, nd);

    bus.cmd_valid = 1'b1;
    bus.cmd_op    = OP_CLEAR;
    wq_addr.delete();
    wq_data.delete();
    @(posedge clk); #1;
    bus.cmd_valid = 1'b0;
    n = 0;
    while (bus.write_address !== 7'd40 && n < 200) begin @(posedge clk); #1; n++; end
    check("clear_reach_40", bus.write_address, 7'd40);
    reset = 1'b1;
    @(posedge clk); #1;
    check("mid_rst_we", bus.write_enable, 1'b0);
    check("mid_rst_busy", busy, 1'b0);
    check("mid_rst_ready", bus.cmd_ready, 1'b0);
    check("mid_rst_live", live_count, 7'd0);
    mlive = 0;
    reset = 1'b0;
    #1;
    check("mid_rst_ready_after", bus.cmd_ready, 1'b1);
    repeat (3) @(posedge clk);
    #1;
    check("mid_rst_write_total", wq_addr.size(), 41);

    run_cmd(OP_CLEAR, 0, nd);
    for (int i = 0; i < 60; i++) begin
      r  = $urandom_range(0, 99);
      op = (r < 3) ? OP_CLEAR : op_e'($urandom_range(1, 3));
      a  = ($urandom_range(0, 9) == 0) ? $urandom_range(100, 127) : $urandom_range(0, 7);
      nd = rand_node();
      pick = $urandom_range(0, 5);
      if (pick == 0) nd.node_id = 16'd0;
      else if (pick == 1) nd.node_id = 16'd800;
      else if (pick < 4 && a < MAXN) nd.node_id = mram[a].node_id;
      else nd.node_id = 16'($urandom_range(1, 6));
      run_cmd(op, a, nd);
    end

    run_cmd(OP_CLEAR, 0, nd);
    for (int i = 0; i < MAXN; i++) begin
      nd = rand_node(); nd.node_id = 16'(i + 1);
      run_cmd(OP_INSERT, i, nd);
    end
    nd = rand_node(); nd.node_id = 16'd200;
    run_cmd(OP_INSERT, 0, nd);
    for (int i = 0; i < MAXN; i++) begin
      nd = rand_node(); nd.node_id = mram[i].node_id;
      run_cmd(OP_REMOVE, i, nd);
    end
    nd = rand_node(); nd.node_id = 16'd5;
    run_cmd(OP_REMOVE, 0, nd);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/queue_node_writer.md
# queue_node_writer

Write-side controller for the pathfinding node queue RAM. It owns the RAM write port and serialises four commands: CLEAR, INSERT, UPDATE and REMOVE. The scan engines (minimum, child-index, child lookup) read the same RAM and depend on this block's slot conventions: node_id 0 marks an empty slot and terminates a scan; node_id 800 marks a removed slot, which is skipped and reusable. The block also maintains a live-entry count for the A* controller.

## Interface
- MAX_NODES, 100, number of RAM entries
- ADDR_W, 7, RAM address width
- clk  in  1  clock
- reset  in  1  reset, synchronous, active-high
- cmd_valid  in  1  command request
- cmd_ready  out  1  high only in IDLE; command accepted on cmd_valid && cmd_ready at a rising edge
- cmd_op  in  2  0 CLEAR, 1 INSERT, 2 UPDATE, 3 REMOVE
- cmd_addr  in  ADDR_W  target slot (ignored for CLEAR)
- cmd_node  in  272  node_info payload
- read_address  out  ADDR_W  RAM read address (registered)
- read_node  in  272  RAM read data, valid one edge after read_address
- write_enable  out  1  RAM write strobe
- write_address  out  ADDR_W  RAM write address
- write_data  out  272  RAM write data
- busy  out  1  state != IDLE
- done  out  1  one-cycle completion pulse
- error  out  1  valid with done; command made no RAM write
- err_code  out  2  0 none, 1 addr >= MAX_NODES, 2 reserved node_id (0 or 800), 3 slot mismatch
- live_count  out  $clog2(MAX_NODES+1)  live entries

## Operation
- States: IDLE, CLEAR_SWEEP, RD_WAIT, CHECK, WRITE, DONE.
- Command fields are latched on accept.
- Accept-time checks:
  - INSERT, UPDATE and REMOVE: cmd_addr >= MAX_NODES gives err 1.
  - INSERT and UPDATE: cmd_node.node_id of 0 or 800 gives err 2.
  - REMOVE: cmd_node.node_id of 0 or 800 also gives err 2.
  - A failed check goes straight to DONE with error set.
- CLEAR:
  - Writes 272'h0 to addresses 0..MAX_NODES-1, one per cycle.
  - Then live_count is set to 0.
  - CLEAR never errors.
- INSERT:
  - Reads the slot. Slot node_id must be 0 or 800; otherwise err 3.
  - Writes cmd_node and increments live_count.
- UPDATE:
  - Reads the slot. Stored node_id must equal cmd_node.node_id; otherwise err 3.
  - Writes the stored entry with only parent_node_id and current_cost replaced from cmd_node.
  - live_count is unchanged.
- REMOVE:
  - Reads the slot. Stored node_id must equal cmd_node.node_id; otherwise err 3.
  - Writes the tombstone: node_id 800, parent 800, current_cost 16'hFFFF, all other fields 0.
  - Decrements live_count.
- live_count saturates at 0 and at MAX_NODES.
- Reset does not touch RAM contents. The controller issues CLEAR after reset.

## Timing
- Reset values: write_enable 0, write_address 0, write_data 0, read_address 0, done 0, error 0, err_code 0, live_count 0, busy 0. cmd_ready is 0 while reset is high.
- E0 is the accept edge.
- INSERT/UPDATE/REMOVE, success:
  - E0 enters RD_WAIT, with read_address = cmd_addr.
  - E1 enters CHECK; read_node is valid.
  - E2 enters WRITE; the write port is registered and write_enable is high for exactly one cycle.
  - E3: RAM commits, state enters DONE, done = 1.
  - E4 returns to IDLE.
- Slot-mismatch error: E2 enters DONE. No write_enable.
- Accept-time error: E0 enters DONE.
- CLEAR: write_enable is high for MAX_NODES consecutive cycles starting after E0. DONE is entered at edge E(MAX_NODES).
- done and error/err_code are high together for one cycle. err_code holds its value until the next accept.
- cmd_ready is low from E0 until the cycle after DONE. No back-to-back accept.
- Reset mid-command: the next edge forces IDLE and clears all outputs. A write already committed stays; no further write is issued.

## Configuration
- QUEUE_WRITER_SLOT_CHECK_EN defined: INSERT and REMOVE perform the read-and-check described above.
- Not defined:
  - INSERT and REMOVE skip the read. E0 enters WRITE; E1 enters DONE.
  - err 3 is only possible for UPDATE.
  - live_count is adjusted without regard to slot contents.
- UPDATE always reads.

## Structure
- Shared pathfinding package holds:
  - the node_info and map_node typedefs
  - NODE_EMPTY_ID = 0 and NODE_REMOVED_ID = 800
  - the TOMBSTONE_NODE constant
  - the op and err_code enums
- The scan engines import the same constants.
- One combinational sub-module, queue_entry_merge: takes op, stored entry and cmd_node; returns the write_data and err_code for CHECK.

## Test plan
- CLEAR with MAX_NODES=100 -> write_enable high for 100 cycles at addresses 0..99 with data 0, then done, live_count 0.
- INSERT id 5, cost 40 at address 0 on a cleared RAM -> write at E2 edge, done at E3, live_count 1. Repeating the INSERT at address 0 -> done with error, err_code 3, no write.
- UPDATE id 5 at address 0 with cost 12, parent 3, x 99 -> RAM holds cost 12, parent 3 and the original x.
- REMOVE id 5 at address 0 -> RAM holds the tombstone, live_count 0. INSERT id 7 at address 0 then succeeds.
- INSERT at address 100 -> err 1 at E0 entry into DONE. INSERT with node_id 800 -> err 2. Neither writes.
- Assert reset during CLEAR at address 40 -> write_enable 0 next cycle, busy 0, cmd_ready 1 after reset deasserts.
